// File: rtl/adder_seq_if.sv
// Valid/ready operand-limb and result-limb streams of the multi-limb adder sequencer.
// master = limb producer / result consumer, slave = the sequencer.
interface adder_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         in_cin;
    logic         in_last;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_last;
    logic         out_carry;
    logic         out_zero;
    logic         len_err;

    modport master (
        output in_valid, in_x, in_y, in_cin, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_carry, out_zero, len_err
    );

    modport slave (
        input  in_valid, in_x, in_y, in_cin, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_carry, out_zero, len_err
    );
endinterface

// File: rtl/adder_seq.sv
// Multi-limb operand sequencer: feeds limbs (LS first) to a registered adder, chains the
// carry between limbs and returns result limbs with last/carry/zero status.
module adder_seq #(
    parameter int W     = 8,
    parameter int LIMBS = 4
) (
    input  logic             clk,
    input  logic             rst,
    adder_seq_if.slave       bus,
    output logic [2*W:0]     ins,
    input  logic [W+1:0]     sm_r,
    input  logic             sm_zero_r
);
    localparam int CW = $clog2(LIMBS) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(LIMBS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            last_q;
    logic            carry_q;
    logic            first_q;
    logic [CW-1:0]   cnt;
    logic            zacc;
    logic            len_err_q;

    logic            accept;
    logic            done;
    logic            at_max;

    logic            in_ready;
    logic            out_valid;
    logic [W-1:0]    out_sum;
    logic            out_carry;
    logic            out_last;
    logic            out_zero;

    // The adder's top sum bit cannot be set by two W-bit limbs plus one carry.
    logic            unused_sm_msb;
    assign unused_sm_msb = sm_r[W+1];

    assign at_max = (cnt == CNT_MAX);
    assign accept = bus.in_valid & (state == IDLE);
    assign done   = bus.out_ready & (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The adder only presents the sum of a new limb during RESP, so the result fields are
    // taken straight from its registered outputs there; ins is frozen, which keeps them
    // stable under backpressure. Outside RESP they read as zero.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_carry = 1'b0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                out_sum   = sm_r[W-1:0];
                out_carry = sm_r[W];
                out_last  = last_q;
                out_zero  = last_q & zacc & sm_zero_r;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins       <= '0;
            last_q    <= 1'b0;
            carry_q   <= 1'b0;
            first_q   <= 1'b1;
            cnt       <= '0;
            zacc      <= 1'b1;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= accept & at_max & ~bus.in_last;
            if (accept) begin
                ins    <= {(first_q ? bus.in_cin : carry_q), bus.in_y, bus.in_x};
                last_q <= bus.in_last | at_max;
            end
            // Releasing the last limb rearms the sequencer for a fresh operand.
            if (done) begin
                if (last_q) begin
                    carry_q <= 1'b0;
                    first_q <= 1'b1;
                    cnt     <= '0;
                    zacc    <= 1'b1;
                end else begin
                    carry_q <= sm_r[W];
                    first_q <= 1'b0;
                    cnt     <= cnt + 1'b1;
                    zacc    <= zacc & (sm_r[W-1:0] == '0);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum;
    assign bus.out_carry = out_carry;
    assign bus.out_last  = out_last;
    assign bus.out_zero  = out_zero;
    assign bus.len_err   = len_err_q;
endmodule

// File: tb/tb_adder_seq.sv
// Directed bench for adder_seq with a behavioural registered adder on the ins/sm_r side.
module tb_adder_seq;
    localparam int W     = 8;
    localparam int LIMBS = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [2*W:0]   ins;
    logic [W+1:0]   sm_r = '0;
    logic           sm_zero_r = 1'b0;
    logic [W+1:0]   sum_c;

    int n_chk = 0;
    int n_err = 0;

    adder_seq_if #(.W(W)) bus ();

    adder_seq #(.W(W), .LIMBS(LIMBS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ins       (ins),
        .sm_r      (sm_r),
        .sm_zero_r (sm_zero_r)
    );

    always #5 clk = ~clk;

    // Registered adder: sum of {cin, y, x} appears one clock after ins changes.
    assign sum_c = {2'b00, ins[W-1:0]} + {2'b00, ins[2*W-1:W]} + {{(W+1){1'b0}}, ins[2*W]};
    always @(posedge clk) begin
        sm_r      <= sum_c;
        sm_zero_r <= (sum_c == '0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " out_sum"},   32'(bus.out_sum),   32'd0);
        chk({tag, " out_last"},  32'(bus.out_last),  32'd0);
        chk({tag, " out_carry"}, 32'(bus.out_carry), 32'd0);
        chk({tag, " out_zero"},  32'(bus.out_zero),  32'd0);
        chk({tag, " len_err"},   32'(bus.len_err),   32'd0);
        chk({tag, " ins"},       32'(ins),           32'd0);
        chk({tag, " in_ready"},  32'(bus.in_ready),  32'd1);
    endtask

    // Offer one limb, then check the accept-side effects and the two-cycle latency.
    task automatic send(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic cin, input logic last, input logic exp_cin,
                        input logic exp_lerr);
        int budget = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_cin   = cin;
        bus.in_last  = last;
        while (!bus.in_ready && budget < 20) begin
            tick();
            budget++;
        end
        if (budget >= 20) chk({tag, " in_ready timeout"}, 32'd0, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, " ins"},        32'(ins), 32'({exp_cin, y, x}));
        chk({tag, " len_err"},    32'(bus.len_err), 32'(exp_lerr));
        chk({tag, " valid t+1"},  32'(bus.out_valid), 32'd0);
        tick();
        chk({tag, " valid t+2"},  32'(bus.out_valid), 32'd1);
        chk({tag, " len_err end"}, 32'(bus.len_err), 32'd0);
    endtask

    task automatic recv(input string tag, input logic [W-1:0] sum, input logic carry,
                        input logic last, input logic zero);
        int budget = 0;
        while (!bus.out_valid && budget < 20) begin
            tick();
            budget++;
        end
        if (budget >= 20) chk({tag, " out_valid timeout"}, 32'd0, 32'd1);
        chk({tag, " sum"},   32'(bus.out_sum),   32'(sum));
        chk({tag, " carry"}, 32'(bus.out_carry), 32'(carry));
        chk({tag, " last"},  32'(bus.out_last),  32'(last));
        chk({tag, " zero"},  32'(bus.out_zero),  32'(zero));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, " released"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " ready"},    32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_cin    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk_idle_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_idle_outputs("after reset");

        // Single limbs
        send("s7f", 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        recv("s7f", 8'h80, 1'b0, 1'b1, 1'b0);
        send("sff", 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        recv("sff", 8'h00, 1'b1, 1'b1, 1'b0);
        send("s00", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        recv("s00", 8'h00, 1'b0, 1'b1, 1'b1);
        send("scin", 8'h10, 8'h20, 1'b1, 1'b1, 1'b1, 1'b0);
        recv("scin", 8'h31, 1'b0, 1'b1, 1'b0);

        // 0x01FF + 0x0001: carry chains, in_cin on limb1 ignored
        send("m0", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        recv("m0", 8'h00, 1'b1, 1'b0, 1'b0);
        send("m1", 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        recv("m1", 8'h02, 1'b0, 1'b1, 1'b0);

        // Zero accumulation across limbs
        send("z0", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        recv("z0", 8'h00, 1'b0, 1'b0, 1'b0);
        send("z1", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        recv("z1", 8'h00, 1'b0, 1'b1, 1'b1);
        send("nz0", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        recv("nz0", 8'h01, 1'b0, 1'b0, 1'b0);
        send("nz1", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        recv("nz1", 8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure: result held, next limb waits
        send("bp", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_x     = 8'h01;
        bus.in_y     = 8'h02;
        bus.in_cin   = 1'b0;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold valid", 32'(bus.out_valid), 32'd1);
            chk("bp hold sum",   32'(bus.out_sum),   32'h30);
            chk("bp hold rdy",   32'(bus.in_ready),  32'd0);
            chk("bp hold ins",   32'(ins),           32'({1'b0, 8'h20, 8'h10}));
        end
        recv("bp", 8'h30, 1'b0, 1'b1, 1'b0);
        send("bp next", 8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
        recv("bp next", 8'h03, 1'b0, 1'b1, 1'b0);

        // Four limbs without in_last: forced last and one len_err pulse
        send("l0", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        recv("l0", 8'h02, 1'b0, 1'b0, 1'b0);
        send("l1", 8'h02, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        recv("l1", 8'h04, 1'b0, 1'b0, 1'b0);
        send("l2", 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        recv("l2", 8'h00, 1'b1, 1'b0, 1'b0);
        send("l3", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        recv("l3", 8'h01, 1'b0, 1'b1, 1'b0);
        send("l4", 8'h05, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0);
        recv("l4", 8'h0B, 1'b0, 1'b1, 1'b0);

        // Reset mid-operand discards carry state
        send("r0", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        recv("r0", 8'h00, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_idle_outputs("mid reset");
        tick();
        rst = 1'b0;
        tick();
        send("r1", 8'h03, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0);
        recv("r1", 8'h07, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
